rv_fifo_rr_arbiter: RTL and testbench
=====================================

// Module: rv_fifo_rr_arbiter
// PURPOSE
//  Shares the write (input) port of one rv_fifo between NUM_REQ ready/valid producers.
//  Uses round-robin arbitration with packet locking on req_last.
//  A burst cap (MAX_BURST beats) prevents one producer from starving the others.
//  Sits directly upstream of rv_fifo: fifo_* ports connect to its data_in/valid_in/ready_in.
// PARAMETERS
//  NUM_REQ    = 4   number of requesters (>=2)
//  DATA_WIDTH = 16  beat width, equal to rv_fifo DATA_WIDTH
//  MAX_BURST  = 4   max beats per grant before forced rotation (>=1)
//  ID_W       = $clog2(NUM_REQ) (localparam) grant index width
// PORTS
//  clk           in   1                   clock, all logic on posedge
//  rst           in   1                   synchronous, active-high reset
//  req_valid     in   NUM_REQ             per-requester valid
//  req_ready     out  NUM_REQ             per-requester ready
//  req_last      in   NUM_REQ             per-requester end-of-packet, qualified by valid
//  req_data      in   NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  fifo_data_in  out  DATA_WIDTH          to rv_fifo data_in
//  fifo_valid_in out  1                   to rv_fifo valid_in
//  fifo_ready_in in   1                   from rv_fifo ready_in (low when full)
//  grant_id      out  ID_W                index of current owner
//  grant_active  out  1                   high while in GRANT state
// BEHAVIOUR
//  Reset values: state=IDLE, grant_id=0, last_grant=NUM_REQ-1, burst_cnt=0.
//   Outputs at reset: fifo_valid_in=0, req_ready=0, grant_active=0, fifo_data_in=0.
//  FSM states: IDLE, GRANT.
//  IDLE:
//   - req_ready=0 and fifo_valid_in=0.
//   - If any req_valid, capture sel = first set bit scanning last_grant+1 upward, modulo NUM_REQ.
//   - On that edge: grant_id<=sel, burst_cnt<=0, state<=GRANT. Arbitration latency is 1 cycle.
//   - No req_valid: stay in IDLE.
//  GRANT (g = grant_id): pure combinational pass-through, zero added latency.
//   - fifo_valid_in = req_valid[g]; fifo_data_in = req_data[g]; req_ready[g] = fifo_ready_in.
//   - All other req_ready bits are 0. Beat accepted when req_valid[g] && fifo_ready_in.
//   - Accepted beat with req_last[g]=1 -> IDLE, last_grant<=g, burst_cnt<=0.
//   - Accepted beat with burst_cnt==MAX_BURST-1 -> IDLE, last_grant<=g (cap wins even mid-packet).
//   - Other accepted beat -> burst_cnt<=burst_cnt+1.
//   - req_valid[g]==0 -> idle release: IDLE, last_grant<=g, no beat transferred.
//   - fifo_ready_in==0 with req_valid[g]=1 (FIFO full) -> hold grant and burst_cnt, no rotation.
//  Every grant ends with one IDLE cycle, so max throughput is MAX_BURST/(MAX_BURST+1) beats/cycle.
//  burst_cnt width is $clog2(MAX_BURST+1); it never exceeds MAX_BURST-1.
//  A requester's valid rising during another's grant waits; no pre-emption.
//  rst mid-burst: on the next edge all state returns to reset values. The beat offered on that edge is not counted.
//  fifo_data_in is don't-care when fifo_valid_in=0. Drive 0 in IDLE.
// STRUCTURE
//  rv_arb_pkg:
//   - typedef enum logic {IDLE, GRANT} arb_state_t
//   - function id_width(n)
//   - the per-lane slice macro/function
//  Sub-module rr_pick #(NUM_REQ): combinational rotate-priority encoder.
//   - Inputs: req, last_grant. Outputs: sel, any.
//  Top: FSM, grant/burst registers, output mux. rv_fifo stays a separate instance in the parent.
// TESTING (bench instantiates arbiter + rv_fifo DEPTH=16, scoreboard queue per requester)
//  1 Reset: rst 10 cycles -> req_ready=0, fifo_valid_in=0, grant_active=0, grant_id=0.
//    After release, FIFO count=0.
//  2 Round-robin: all 4 req_valid=1, single-beat packets (last=1).
//    -> grants in order 0,1,2,3,0. One beat each, every 2 cycles.
//  3 Burst cap: req0 sends 10-beat packet, req1 valid. MAX_BURST=4.
//    -> 4 beats from 0, then 4 from 1, then the remaining 6 from 0 in 4+2.
//    -> per-requester order is preserved in the FIFO.
//  4 Backpressure: fill FIFO to full (count=16, ready_in=0) with req2 granted.
//    -> grant_id stays 2 and burst_cnt frozen. Pop 1 entry -> exactly one beat accepted.
//  5 Idle release: req3 granted, drops valid after 1 beat with last=0.
//    -> IDLE next cycle. req0 then granted before req3 regains the grant.
//  6 Reset mid-burst: assert rst during beat 2 of a 4-beat burst.
//    -> next cycle grant_active=0. last_grant reset, so req0 is granted first.

Source files
------------

// File: rtl/rv_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write-port arbiter.
package rv_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // Grant index width; a single requester still needs one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB position of lane `lane` in a flat bus of `width`-bit lanes.
    function automatic int unsigned lane_base(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request strictly after last_grant, wrapping.
module rr_pick
    import rv_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    sel,
    output logic               any
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        // i runs 1..NUM_REQ so last_grant itself is checked last.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((32'(last_grant) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rv_fifo_rr_arbiter.sv
// Round-robin arbiter sharing one rv_fifo write port between NUM_REQ producers,
// with packet locking on req_last and a MAX_BURST cap per grant.
module rv_fifo_rr_arbiter
    import rv_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = 4,
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  int unsigned MAX_BURST  = 4,
    localparam int unsigned ID_W       = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic                          fifo_valid_in,
    input  logic                          fifo_ready_in,
    output logic [ID_W-1:0]               grant_id,
    output logic                          grant_active
);

    localparam int unsigned     BURST_W   = $clog2(MAX_BURST + 1);
    localparam logic [BURST_W-1:0] BurstLast = BURST_W'(MAX_BURST - 1);

    arb_state_t         state_q, state_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [BURST_W-1:0] burst_q, burst_d;

    logic [ID_W-1:0]       pick_sel;
    logic                  pick_any;
    logic [DATA_WIDTH-1:0] lane_data [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane_data[i] = req_data[lane_base(i, DATA_WIDTH) +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_pick (
        .req       (req_valid),
        .last_grant(last_q),
        .sel       (pick_sel),
        .any       (pick_any)
    );

    // Zero-latency pass-through from the owner while granted.
    always_comb begin
        req_ready     = '0;
        fifo_valid_in = 1'b0;
        fifo_data_in  = '0;
        if (state_q == GRANT) begin
            fifo_valid_in      = req_valid[grant_q];
            fifo_data_in       = lane_data[grant_q];
            req_ready[grant_q] = fifo_ready_in;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_sel;
                    burst_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req_valid[grant_q]) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                    burst_d = '0;
                end else if (fifo_ready_in) begin
                    // Burst cap ends the grant even in the middle of a packet.
                    if (req_last[grant_q] || (burst_q == BurstLast)) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    assign grant_id     = grant_q;
    assign grant_active = (state_q == GRANT);

endmodule

// File: tb/tb_rv_fifo_rr_arbiter.sv
// Directed bench for rv_fifo_rr_arbiter: counting sources per requester and a
// 16-deep FIFO model on the write side; checks grant order, caps, stalls and reset.
module tb_rv_fifo_rr_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid, req_ready, req_last;
    logic [N*DW-1:0] req_data;
    logic [DW-1:0] fifo_data_in;
    logic          fifo_valid_in, fifo_ready_in;
    logic [1:0]    grant_id;
    logic          grant_active;

    always #5 clk = ~clk;

    rv_fifo_rr_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_last     (req_last),
        .req_data     (req_data),
        .fifo_data_in (fifo_data_in),
        .fifo_valid_in(fifo_valid_in),
        .fifo_ready_in(fifo_ready_in),
        .grant_id     (grant_id),
        .grant_active (grant_active)
    );

    // Sources: beat data is {id, running beat count}; valid while count < target.
    int unsigned cnt    [N] = '{default: 0};
    int unsigned target [N] = '{default: 0};
    int unsigned pstart [N] = '{default: 0};
    int unsigned plen   [N] = '{default: 1};

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = cnt[i] < target[i];
            req_last[i]           = ((cnt[i] - pstart[i]) % plen[i]) == plen[i] - 1;
            req_data[i*DW +: DW]  = {4'(i), 12'(cnt[i])};
        end
    end

    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) cnt[i] <= cnt[i] + 1;
            end
        end
    end

    // FIFO model plus a log of every accepted beat and its cycle.
    logic [DW-1:0] fifo_mem [$];
    logic [DW-1:0] popped   [$];
    logic [DW-1:0] log_d    [$];
    int            log_t    [$];
    int            fifo_cnt = 0;
    logic          pop_en   = 1'b0;

    assign fifo_ready_in = (fifo_cnt < DEPTH);

    always @(posedge clk) begin
        if (rst) begin
            fifo_mem.delete();
            fifo_cnt <= 0;
        end else begin
            if (pop_en && fifo_mem.size() > 0) popped.push_back(fifo_mem.pop_front());
            if (fifo_valid_in && fifo_ready_in) begin
                fifo_mem.push_back(fifo_data_in);
                log_d.push_back(fifo_data_in);
                log_t.push_back(cyc);
            end
            fifo_cnt <= fifo_mem.size();
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int pop_chk  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input int i, input int unsigned beats, input int unsigned len);
        pstart[i] = cnt[i];
        plen[i]   = len;
        target[i] = cnt[i] + beats;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) if (cnt[i] < target[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget && !all_done(); k++) tick();
        check_val(tag, 32'(all_done()), 1);
    endtask

    // Empty the FIFO and confirm it held exactly the accepted beats, in order.
    task automatic drain(input string tag);
        pop_en = 1'b1;
        for (int k = 0; k < 40 && fifo_cnt != 0; k++) tick();
        pop_en = 1'b0;
        check_val({tag, "_empty"}, fifo_cnt, 0);
        check_val({tag, "_popcnt"}, popped.size(), log_d.size());
        while (pop_chk < popped.size() && pop_chk < log_d.size()) begin
            check_val({tag, "_order"}, popped[pop_chk], log_d[pop_chk]);
            pop_chk++;
        end
    endtask

    task automatic check_log(input string tag, input int base, input logic [DW-1:0] exp [],
                             input int n);
        check_val({tag, "_nbeats"}, log_d.size() - base, n);
        for (int k = 0; k < n; k++) begin
            if (base + k < log_d.size()) check_val({tag, "_beat"}, log_d[base+k], exp[k]);
        end
    endtask

    logic [DW-1:0] t2_exp [] = '{16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h0001};
    logic [DW-1:0] t3_exp [] = '{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h1001, 16'h1002,
                                 16'h1003, 16'h1004, 16'h0006, 16'h0007, 16'h0008, 16'h0009,
                                 16'h000A, 16'h000B};
    logic [DW-1:0] t5_exp [] = '{16'h3001, 16'h000C, 16'h3002};
    logic [DW-1:0] t6_exp [] = '{16'h000E, 16'h1006, 16'h1007, 16'h1008};

    initial begin
        int b;
        int n;

        // Reset
        repeat (10) tick();
        check_val("rst_ready", req_ready, 0);
        check_val("rst_valid", fifo_valid_in, 0);
        check_val("rst_active", grant_active, 0);
        check_val("rst_gid", grant_id, 0);
        check_val("rst_data", fifo_data_in, 0);
        rst = 1'b0;
        tick();
        check_val("rst_fifo_cnt", fifo_cnt, 0);
        check_val("rst_idle_stay", grant_active, 0);

        // Round-robin over single-beat packets
        start_req(0, 2, 1);
        start_req(1, 1, 1);
        start_req(2, 1, 1);
        start_req(3, 1, 1);
        #1;
        check_val("t2_idle_ready", req_ready, 0);
        check_val("t2_idle_valid", fifo_valid_in, 0);
        b = log_d.size();
        tick();
        check_val("t2_active", grant_active, 1);
        check_val("t2_gid", grant_id, 0);
        check_val("t2_valid", fifo_valid_in, 1);
        check_val("t2_ready", req_ready, 4'b0001);
        wait_done("t2_done", 30);
        check_log("t2", b, t2_exp, 5);
        for (int k = 0; k < 4; k++) begin
            if (b + k + 1 < log_t.size()) check_val("t2_gap", log_t[b+k+1] - log_t[b+k], 2);
        end
        drain("t2");

        // Burst cap with a competing requester
        start_req(0, 10, 10);
        b = log_d.size();
        tick();
        check_val("t3_gid", grant_id, 0);
        start_req(1, 4, 4);
        wait_done("t3_done", 60);
        check_log("t3", b, t3_exp, 14);
        if (b + 13 < log_t.size()) check_val("t3_span", log_t[b+13] - log_t[b], 16);
        drain("t3");

        // Backpressure from a full FIFO
        start_req(2, 100, 1000);
        for (int k = 0; k < 80 && fifo_cnt != DEPTH; k++) tick();
        check_val("t4_full", fifo_cnt, DEPTH);
        repeat (3) tick();
        check_val("t4_hold_gid", grant_id, 2);
        check_val("t4_hold_active", grant_active, 1);
        check_val("t4_hold_valid", fifo_valid_in, 1);
        check_val("t4_hold_ready", req_ready, 0);
        n = log_d.size();
        for (int p = 1; p <= 4; p++) begin
            pop_en = 1'b1;
            tick();
            pop_en = 1'b0;
            tick();
            check_val("t4_one_beat", log_d.size() - n, p);
            if (p < 4) begin
                check_val("t4_still_active", grant_active, 1);
                check_val("t4_still_gid", grant_id, 2);
                tick();
                tick();
                check_val("t4_no_extra", log_d.size() - n, p);
            end else begin
                check_val("t4_cap_release", grant_active, 0);
            end
        end
        tick();
        check_val("t4_regrant", grant_active, 1);
        check_val("t4_regrant_gid", grant_id, 2);
        target[2] = cnt[2];
        tick();
        check_val("t4_stop_release", grant_active, 0);
        drain("t4");

        // Idle release: owner drops valid mid-packet
        b = log_d.size();
        start_req(3, 1, 100);
        start_req(0, 1, 1);
        tick();
        check_val("t5_gid3", grant_id, 3);
        check_val("t5_valid", fifo_valid_in, 1);
        tick();
        check_val("t5_grant_held", grant_active, 1);
        check_val("t5_valid_low", fifo_valid_in, 0);
        tick();
        check_val("t5_idle", grant_active, 0);
        start_req(3, 1, 1);
        tick();
        check_val("t5_gid0", grant_id, 0);
        check_val("t5_active0", grant_active, 1);
        wait_done("t5_done", 20);
        check_log("t5", b, t5_exp, 3);
        drain("t5");

        // Reset in the middle of a burst
        start_req(0, 1, 1);
        wait_done("t6_pre", 20);
        start_req(1, 4, 4);
        tick();
        check_val("t6_gid1", grant_id, 1);
        tick();
        if (log_d.size() > 0) check_val("t6_beat1", log_d[log_d.size()-1], 16'h1005);
        rst = 1'b1;
        start_req(0, 1, 1);
        tick();
        check_val("t6_rst_active", grant_active, 0);
        check_val("t6_rst_gid", grant_id, 0);
        check_val("t6_rst_ready", req_ready, 0);
        check_val("t6_rst_valid", fifo_valid_in, 0);
        check_val("t6_rst_fifo", fifo_cnt, 0);
        rst = 1'b0;
        b = log_d.size();
        tick();
        check_val("t6_first_gid", grant_id, 0);
        check_val("t6_first_active", grant_active, 1);
        wait_done("t6_done", 30);
        check_log("t6", b, t6_exp, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
